ttt_btn_debouncer: RTL and testbench
====================================

// Module: ttt_btn_debouncer
// PURPOSE
//  Input-side counterpart of the tic-tac-toe SSD/state display: conditions raw pushbuttons for the game FSM.
//  Per button: 2-flop synchroniser, debounce FSM, one-cycle press pulse (SCEN), and a repeat pulse train (MCEN).
//  Sits between the board pins {BtnU,BtnD,BtnL,BtnR} and sm_ttt / the move-entry logic; runs on board_clk.
// PARAMETERS
//  N_BTNS          4           number of independent button channels (bit3..0 = UP,DOWN,L,R)
//  DEBOUNCE_CYCLES 2_500_000   cycles the synchronised input must be stable (25 ms @100 MHz); min 2
//  REPEAT_DELAY    50_000_000  hold cycles from SCEN to first repeat MCEN (BTN_AUTOREPEAT_EN only)
//  REPEAT_PERIOD   10_000_000  hold cycles between later repeat MCENs (BTN_AUTOREPEAT_EN only)
// PORTS
//  Clk       in   1       system clock; all state on rising edge
//  reset     in   1       asynchronous, active-high reset
//  btn_in    in   N_BTNS  raw asynchronous button pins, 1 = pressed
//  btn_db    out  N_BTNS  debounced level per button
//  btn_scen  out  N_BTNS  single-clock enable: exactly one 1-cycle pulse per accepted press
//  btn_mcen  out  N_BTNS  multi-clock enable: press pulse plus auto-repeat pulses while held
// BEHAVIOUR
//  Reset: sync flops 0, every channel FSM in INI, counters 0; btn_db/btn_scen/btn_mcen all 0.
//  Synchroniser: pin sampled at edge k appears on the FSM input btn_s after edge k+1.
//  Per-channel Moore FSM; counter cnt cleared on every state change:
//   INI : btn_s=1 -> WQ.
//   WQ  : btn_s=0 -> INI; cnt==DEBOUNCE_CYCLES-1 and btn_s=1 -> SCEN_ST; else cnt++.
//   SCEN_ST : one cycle; -> HOLD unconditionally; btn_scen=1, btn_mcen=1.
//   HOLD: btn_s=0 -> WFR; repeat timer expiry (macro on) -> MCEN_ST; else cnt++.
//   MCEN_ST : one cycle; btn_mcen=1 only; -> HOLD (cnt cleared; next interval REPEAT_PERIOD).
//   WFR : btn_s=1 -> HOLD (glitch absorbed, no new SCEN); cnt==DEBOUNCE_CYCLES-1 and btn_s=0 -> INI.
//  btn_db=1 in SCEN_ST, HOLD, MCEN_ST, WFR; 0 in INI, WQ.
//  Latency: pin rises and stays high from edge k -> btn_scen high for the one cycle after edge k+2+DEBOUNCE_CYCLES.
//   Pin falls and stays low from edge k -> btn_db falls after edge k+2+DEBOUNCE_CYCLES.
//  Bounce: any low sample in WQ restarts from INI. Pulses shorter than DEBOUNCE_CYCLES are never reported.
//  Counter width $clog2 of the largest active parameter + 1. Saturates and never wraps.
//  Channels are fully independent. Simultaneous presses give same-cycle pulses on each channel.
//  Reset mid-operation: immediate return to INI/outputs 0. A button held across reset release is re-debounced.
//   It yields exactly one SCEN, DEBOUNCE_CYCLES+2 cycles after reset release.
//  Outputs are registered-state decodes: no combinational path from btn_in to any output.
// CONFIGURATION
//  Macro BTN_AUTOREPEAT_EN.
//   Defined: HOLD counts toward REPEAT_DELAY after SCEN, then REPEAT_PERIOD after each MCEN_ST.
//    MCEN_ST is entered when cnt reaches the interval minus 1.
//   Undefined: MCEN_ST and repeat counting are not built; btn_mcen == btn_scen.
//    REPEAT_DELAY and REPEAT_PERIOD are ignored.
// STRUCTURE
//  Shared package ttt_pkg: channel state encodings (INI, WQ, SCEN_ST, HOLD, MCEN_ST, WFR; 3-bit) and button index constants.
//   Index constants: BTN_UP=3, BTN_DOWN=2, BTN_L=1, BTN_R=0.
//  Sub-module ttt_btn_debounce_ch: one channel (synchroniser + FSM + counter).
//   Top level instantiates it N_BTNS times with a generate loop and concatenates outputs.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//  1 Clean press: btn_in[3] high at edge 10 for 30 cycles.
//    -> btn_scen[3]=btn_mcen[3]=1 only in cycle after edge 16; btn_db[3] 1 from edge 16.
//    -> After the pin falls at edge 40, btn_db[3] clears at edge 46. No other channel toggles.
//  2 Bounce: btn_in[0] = 1,0,1,1,0,1 over 6 cycles, then steady 1 for 20.
//    -> exactly one btn_scen[0] pulse, 6 cycles after the last rising edge.
//  3 Release glitch: held press with one-cycle low, later a 3-cycle low.
//    -> btn_db stays 1 throughout; no second btn_scen.
//  4 Auto-repeat, macro on, hold 40 cycles after SCEN -> btn_mcen pulses at SCEN, SCEN+11, +6, +6, +6...
//    Macro off -> btn_mcen identical to btn_scen.
//  5 Reset mid-press: assert reset while channel in WQ -> all outputs 0 same cycle.
//    Release reset with pin held -> one btn_scen 6 cycles after release.
//  6 All four pins rise on the same edge -> btn_scen=4'b1111 in a single cycle, one pulse each.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe pushbutton front end:
// channel FSM state encodings, button index constants and a small helper.
package ttt_pkg;

    // Per-channel debounce FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        INI     = 3'd0,
        WQ      = 3'd1,
        SCEN_ST = 3'd2,
        HOLD    = 3'd3,
        MCEN_ST = 3'd4,
        WFR     = 3'd5
    } ch_state_t;

    // Bit positions of the board buttons inside btn_in / btn_* vectors
    localparam int unsigned BTN_UP   = 3;
    localparam int unsigned BTN_DOWN = 2;
    localparam int unsigned BTN_L    = 1;
    localparam int unsigned BTN_R    = 0;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ttt_btn_debounce_ch.sv
// One pushbutton channel: 2-flop synchroniser, debounce FSM with a
// saturating counter, and registered level / press / repeat outputs.
// Optional auto-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module ttt_btn_debounce_ch
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic Clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_db,
    output logic o_scen,
    output logic o_mcen
);

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned CNT_SPAN = max2(DEBOUNCE_CYCLES, max2(REPEAT_DELAY, REPEAT_PERIOD));
`else
    localparam int unsigned CNT_SPAN = DEBOUNCE_CYCLES;
    // Repeat timing has no effect without auto-repeat
    localparam int unsigned unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_SPAN) + 1;

    logic             r_sync1;
    logic             r_sync2;
    ch_state_t        r_state;
    ch_state_t        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_inc;
    logic             w_btn_s;
    logic             w_db_done;
    logic             r_db;
    logic             r_scen;
    logic             r_mcen;

    assign w_btn_s   = r_sync2;
    assign w_db_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

`ifdef BTN_AUTOREPEAT_EN
    logic             r_first;
    logic             w_rpt_done;

    // First interval after a press is the long delay, later ones the period
    assign w_rpt_done = r_first ? (r_cnt == CNT_W'(REPEAT_DELAY - 1))
                                : (r_cnt == CNT_W'(REPEAT_PERIOD - 1));

    // Track whether the next repeat interval is the initial delay
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_first <= 1'b0;
        end else if (w_next_state == SCEN_ST) begin
            r_first <= 1'b1;
        end else if (w_next_state == MCEN_ST) begin
            r_first <= 1'b0;
        end
    end
`endif

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state decision for the debounce FSM
    always_comb begin
        w_next_state = r_state;
        w_cnt_inc    = 1'b0;
        unique case (r_state)
            INI: begin
                if (w_btn_s) w_next_state = WQ;
            end
            WQ: begin
                if (!w_btn_s)      w_next_state = INI;
                else if (w_db_done) w_next_state = SCEN_ST;
                else               w_cnt_inc    = 1'b1;
            end
            SCEN_ST: begin
                w_next_state = HOLD;
            end
            HOLD: begin
                if (!w_btn_s)       w_next_state = WFR;
`ifdef BTN_AUTOREPEAT_EN
                else if (w_rpt_done) w_next_state = MCEN_ST;
`endif
                else                w_cnt_inc    = 1'b1;
            end
            MCEN_ST: begin
                w_next_state = HOLD;
            end
            WFR: begin
                if (w_btn_s)        w_next_state = HOLD;
                else if (w_db_done) w_next_state = INI;
                else                w_cnt_inc    = 1'b1;
            end
            default: begin
                w_next_state = INI;
            end
        endcase
    end

    // Counter clears on any state change and saturates instead of wrapping
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next_state != r_state) begin
            w_cnt_next = '0;
        end else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // State, counter and output registers (outputs decoded from next state)
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= INI;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_scen  <= 1'b0;
            r_mcen  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_db    <= (w_next_state != INI) && (w_next_state != WQ);
            r_scen  <= (w_next_state == SCEN_ST);
`ifdef BTN_AUTOREPEAT_EN
            r_mcen  <= (w_next_state == SCEN_ST) || (w_next_state == MCEN_ST);
`else
            r_mcen  <= (w_next_state == SCEN_ST);
`endif
        end
    end

    assign o_db   = r_db;
    assign o_scen = r_scen;
    assign o_mcen = r_mcen;

endmodule

// File: rtl/ttt_btn_debouncer.sv
// Pushbutton conditioner for the tic-tac-toe game: N_BTNS independent
// debounce channels (bit3..0 = UP, DOWN, L, R) producing debounced level,
// single press pulse and multi-pulse (auto-repeat) enables.
// Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module ttt_btn_debouncer
    import ttt_pkg::*;
#(
    parameter int unsigned N_BTNS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 2_500_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [N_BTNS-1:0] btn_in,
    output logic [N_BTNS-1:0] btn_db,
    output logic [N_BTNS-1:0] btn_scen,
    output logic [N_BTNS-1:0] btn_mcen
);

    // One fully independent channel per button
    for (genvar g = 0; g < int'(N_BTNS); g++) begin : g_ch
        ttt_btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .Clk    (Clk),
            .reset  (reset),
            .i_btn  (btn_in[g]),
            .o_db   (btn_db[g]),
            .o_scen (btn_scen[g]),
            .o_mcen (btn_mcen[g])
        );
    end

endmodule

// File: tb/tb_ttt_btn_debouncer.sv
// Bench for ttt_btn_debouncer: directed scenarios with literal expectations
// plus randomized pin activity, all checked every cycle against a run-length
// model of the button behaviour.
module tb_ttt_btn_debouncer;

    localparam int unsigned NB = 4;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] pins = '0;
    logic [NB-1:0] btn_db;
    logic [NB-1:0] btn_scen;
    logic [NB-1:0] btn_mcen;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    ttt_btn_debouncer #(
        .N_BTNS          (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .Clk      (clk),
        .reset    (rst),
        .btn_in   (pins),
        .btn_db   (btn_db),
        .btn_scen (btn_scen),
        .btn_mcen (btn_mcen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: pin seen by the debouncer two edges late; a level flips after
    // DB+1 consecutive opposite samples; the sample right after a pulse is ignored.
    bit          h1[NB], h2[NB], m_l[NB], m_blind[NB], m_first[NB];
    int unsigned m_ones[NB], m_zeros[NB];
    logic [NB-1:0] e_db, e_scen, e_mcen;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NB; c++) begin
                h1[c] = 0; h2[c] = 0; m_l[c] = 0; m_blind[c] = 0; m_first[c] = 0;
                m_ones[c] = 0; m_zeros[c] = 0;
            end
            e_db = '0; e_scen = '0; e_mcen = '0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                bit s;
                s = h2[c]; h2[c] = h1[c]; h1[c] = pins[c];
                e_scen[c] = 1'b0; e_mcen[c] = 1'b0;
                if (m_blind[c]) begin
                    m_blind[c] = 0; m_ones[c] = 0; m_zeros[c] = 0;
                end else if (!m_l[c]) begin
                    if (s) begin
                        m_ones[c]++;
                        if (m_ones[c] == DB + 1) begin
                            m_l[c] = 1; m_ones[c] = 0; m_blind[c] = 1; m_first[c] = 1;
                            e_scen[c] = 1'b1; e_mcen[c] = 1'b1;
                        end
                    end else begin
                        m_ones[c] = 0;
                    end
                end else if (!s) begin
                    m_zeros[c]++;
                    if (m_zeros[c] == DB + 1) begin
                        m_l[c] = 0; m_zeros[c] = 0; m_ones[c] = 0;
                    end
                end else if (m_zeros[c] != 0) begin
                    m_zeros[c] = 0; m_ones[c] = 0;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    m_ones[c]++;
                    if (m_ones[c] == (m_first[c] ? RD : RP)) begin
                        e_mcen[c] = 1'b1; m_blind[c] = 1; m_first[c] = 0;
                    end
`endif
                end
                e_db[c] = m_l[c];
            end
        end
        #1;
        chk("model_db",   int'(btn_db),   int'(e_db));
        chk("model_scen", int'(btn_scen), int'(e_scen));
        chk("model_mcen", int'(btn_mcen), int'(e_mcen));
    end

    // Per-channel press-pulse and low-level cycle counts
    int unsigned pcnt[NB], lowcnt[NB];
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NB; c++) begin
                if (btn_scen[c]) pcnt[c]++;
                if (!btn_db[c])  lowcnt[c]++;
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bit pat[6];
        int unsigned snap, snap_lo;
        int unsigned hold_left[NB];
        int exp_rep;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < NB; c++) begin pcnt[c] = 0; lowcnt[c] = 0; hold_left[c] = 0; end
`ifdef BTN_AUTOREPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 0;
`endif

        // Reset state
        wait_edges(3);
        @(negedge clk) rst = 1'b0;
        wait_edges(2);
        chk("reset_db",   int'(btn_db),   0);
        chk("reset_scen", int'(btn_scen), 0);

        // Clean press on UP, then release
        @(negedge clk) pins[3] = 1'b1;
        wait_edges(6);
        chk("press_early_scen", int'(btn_scen), 0);
        chk("press_early_db",   int'(btn_db),   0);
        wait_edges(1);
        chk("press_scen", int'(btn_scen), 8);
        chk("press_mcen", int'(btn_mcen), 8);
        chk("press_db",   int'(btn_db),   8);
        wait_edges(1);
        chk("press_after_scen", int'(btn_scen), 0);
        wait_edges(21);
        @(negedge clk) pins[3] = 1'b0;
        wait_edges(6);
        chk("release_db_held", int'(btn_db), 8);
        wait_edges(1);
        chk("release_db_low", int'(btn_db), 0);
        wait_edges(5);

        // Bounce on R
        snap = pcnt[0];
        for (int i = 0; i < 6; i++) @(negedge clk) pins[0] = pat[i];
        wait_edges(6);
        chk("bounce_early", int'(btn_scen), 0);
        wait_edges(1);
        chk("bounce_scen", int'(btn_scen), 1);
        wait_edges(15);
        chk("bounce_one_pulse", int'(pcnt[0] - snap), 1);
        @(negedge clk) pins[0] = 1'b0;
        wait_edges(12);

        // Release glitches on L: 1-cycle and 3-cycle lows are absorbed
        @(negedge clk) pins[1] = 1'b1;
        wait_edges(12);
        snap = pcnt[1]; snap_lo = lowcnt[1];
        @(negedge clk) pins[1] = 1'b0;
        @(negedge clk) pins[1] = 1'b1;
        wait_edges(6);
        @(negedge clk) pins[1] = 1'b0;
        wait_edges(3);
        @(negedge clk) pins[1] = 1'b1;
        wait_edges(10);
        chk("glitch_no_rescen", int'(pcnt[1] - snap), 0);
        chk("glitch_db_held",   int'(lowcnt[1] - snap_lo), 0);
        @(negedge clk) pins[1] = 1'b0;
        wait_edges(12);

        // Auto-repeat timing on DOWN
        @(negedge clk) pins[2] = 1'b1;
        wait_edges(7);
        chk("rep_scen", int'(btn_scen), 4);
        wait_edges(10);
        chk("rep_gap", int'(btn_mcen), 0);
        wait_edges(1);
        chk("rep_first", int'(btn_mcen), exp_rep);
        wait_edges(6);
        chk("rep_second", int'(btn_mcen), exp_rep);
        wait_edges(20);
        @(negedge clk) pins[2] = 1'b0;
        wait_edges(12);

        // Reset mid-press, button held across reset release
        @(negedge clk) pins[3] = 1'b1;
        wait_edges(12);
        @(negedge clk) pins[2] = 1'b1;
        wait_edges(3);
        chk("rst_pre_db", int'(btn_db), 8);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_async_db",   int'(btn_db),   0);
        chk("rst_async_mcen", int'(btn_mcen), 0);
        wait_edges(2);
        @(negedge clk) rst = 1'b0;
        wait_edges(6);
        chk("rst_rel_early", int'(btn_scen), 0);
        wait_edges(1);
        chk("rst_rel_scen", int'(btn_scen), 12);
        @(negedge clk) pins = '0;
        wait_edges(12);

        // All four buttons at once
        snap = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
        @(negedge clk) pins = 4'hF;
        wait_edges(6);
        chk("all_early", int'(btn_scen), 0);
        wait_edges(1);
        chk("all_scen", int'(btn_scen), 15);
        wait_edges(1);
        chk("all_after", int'(btn_scen), 0);
        wait_edges(20);
        chk("all_one_each", int'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3] - snap), 4);
        @(negedge clk) pins = '0;
        wait_edges(12);

        // Randomized pin activity with occasional resets
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < NB; c++) begin
                if (hold_left[c] == 0) begin
                    pins[c] = ~pins[c];
                    hold_left[c] = $urandom_range(1, 30);
                end else begin
                    hold_left[c]--;
                end
            end
        end
        @(negedge clk) begin rst = 1'b0; pins = '0; end
        wait_edges(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
